// File: rtl/score_segment_decoder.sv
// score_segment_decoder
// Turns a time-multiplexed stream of active-low seven-segment digit beats
// back into a 16-bit score. Four nibbles are captured by digit position.
// The assembled frame is then offered on a valid/ready handshake.
//
// Build option: define SEGDEC_ERR_EN to enable illegal-pattern detection.
// With it defined, an illegal beat clears its capture bit and pulses err.
// With it undefined, unknown patterns decode to 0 and count as legal,
// and err is tied low.
module score_segment_decoder (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        seg_valid,
    output logic        seg_ready,
    input  logic [6:0]  seg_in,
    input  logic [1:0]  digit_idx,
    output logic [15:0] score_out,
    output logic        score_valid,
    input  logic        score_ready,
    output logic        err
);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

`ifdef SEGDEC_ERR_EN
    localparam logic UNKNOWN_IS_LEGAL = 1'b0;
`else
    localparam logic UNKNOWN_IS_LEGAL = 1'b1;
`endif

    // Returns {legal, nibble}. Segment bit i drives segment i, and 0 means lit.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h18:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h03:   r = {1'b1, 4'hB};
            7'h46:   r = {1'b1, 4'hC};
            7'h21:   r = {1'b1, 4'hD};
            7'h06:   r = {1'b1, 4'hE};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = {UNKNOWN_IS_LEGAL, 4'h0};
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] digits_q, digits_d;
    logic [15:0] score_out_q, score_out_d;
    logic        score_valid_q, score_valid_d;
    logic [4:0]  dec_s;
`ifdef SEGDEC_ERR_EN
    logic        err_q, err_d;
`endif

    assign dec_s       = seg_decode(seg_in);
    assign seg_ready   = (state_q == ST_COLLECT);
    assign score_out   = score_out_q;
    assign score_valid = score_valid_q;
`ifdef SEGDEC_ERR_EN
    assign err         = err_q;
`else
    assign err         = 1'b0;
`endif

    // Next-state logic: capture beats while collecting and hold the frame until it is consumed.
    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        digits_d      = digits_q;
        score_out_d   = score_out_q;
        score_valid_d = score_valid_q;
`ifdef SEGDEC_ERR_EN
        err_d         = 1'b0;
`endif
        case (state_q)
            ST_COLLECT: begin
                if (seg_valid) begin
                    if (dec_s[4]) begin
                        digits_d[{digit_idx, 2'b00} +: 4] = dec_s[3:0];
                        mask_d[digit_idx]                 = 1'b1;
                        // The frame completes on the same edge as the last
                        // digit, so include the nibble just written.
                        if (mask_d == 4'b1111) begin
                            state_d       = ST_HOLD;
                            score_out_d   = digits_d;
                            score_valid_d = 1'b1;
                        end else begin
                            state_d = ST_COLLECT;
                        end
                    end else begin
                        // An illegal beat invalidates that position. A fresh
                        // legal beat is then needed before the frame can complete.
                        mask_d[digit_idx] = 1'b0;
`ifdef SEGDEC_ERR_EN
                        err_d             = 1'b1;
`endif
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_HOLD: begin
                if (score_ready) begin
                    state_d       = ST_COLLECT;
                    score_valid_d = 1'b0;
                    mask_d        = 4'b0000;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d       = ST_COLLECT;
                mask_d        = 4'b0000;
                score_valid_d = 1'b0;
            end
        endcase
    end

    // State registers: reset or enable low clears everything, including any pending frame.
    always_ff @(posedge clk) begin
        if (!resetn || !enable) begin
            state_q       <= ST_COLLECT;
            mask_q        <= 4'b0000;
            digits_q      <= 16'h0000;
            score_out_q   <= 16'h0000;
            score_valid_q <= 1'b0;
`ifdef SEGDEC_ERR_EN
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            digits_q      <= digits_d;
            score_out_q   <= score_out_d;
            score_valid_q <= score_valid_d;
`ifdef SEGDEC_ERR_EN
            err_q         <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_score_segment_decoder.sv
// Self-checking bench for score_segment_decoder.
// Expected frames are queued when their completing beat is driven. A monitor
// pops each one and compares it when score_valid rises.
module tb_score_segment_decoder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic        seg_valid;
    logic        seg_ready;
    logic [6:0]  seg_in;
    logic [1:0]  digit_idx;
    logic [15:0] score_out;
    logic        score_valid;
    logic        score_ready;
    logic        err;

    int n_checks = 0;
    int n_fails  = 0;
    logic [15:0] exp_q[$];
    logic        prev_valid = 1'b0;

    score_segment_decoder dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .seg_valid   (seg_valid),
        .seg_ready   (seg_ready),
        .seg_in      (seg_in),
        .digit_idx   (digit_idx),
        .score_out   (score_out),
        .score_valid (score_valid),
        .score_ready (score_ready),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: on each rising score_valid, compare against the oldest expected frame.
    always @(negedge clk) begin
        if (score_valid === 1'b1 && prev_valid !== 1'b1) begin
            if (exp_q.size() > 0) begin
                chk("frame", {16'h0000, score_out}, {16'h0000, exp_q.pop_front()});
            end else begin
                chk("spurious_frame", {31'd0, score_valid}, 32'd0);
            end
        end
        prev_valid <= score_valid;
    end

    // Present one beat and wait for it to be accepted, with a bounded wait.
    task automatic send(input logic [1:0] idx, input logic [6:0] pat);
        int waited;
        seg_valid = 1'b1;
        seg_in    = pat;
        digit_idx = idx;
        waited    = 0;
        while (seg_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (seg_ready !== 1'b1) begin
            chk("seg_ready_timeout", {31'd0, seg_ready}, 32'd1);
        end
        @(posedge clk); #1;
        seg_valid = 1'b0;
    endtask

    task automatic release_frame();
        score_ready = 1'b1;
        @(posedge clk); #1;
        score_ready = 1'b0;
        chk("release_valid", {31'd0, score_valid}, 32'd0);
        chk("release_ready", {31'd0, seg_ready}, 32'd1);
    endtask

    initial begin
        resetn      = 1'b0;
        enable      = 1'b1;
        seg_valid   = 1'b0;
        seg_in      = 7'h7F;
        digit_idx   = 2'd0;
        score_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        chk("rst_ready", {31'd0, seg_ready}, 32'd1);
        chk("rst_out",   {16'h0000, score_out}, 32'h0000);
        chk("rst_valid", {31'd0, score_valid}, 32'd0);
        chk("rst_err",   {31'd0, err}, 32'd0);

        // Ordered frame.
        send(2'd0, 7'h19);
        send(2'd1, 7'h30);
        chk("partial_valid", {31'd0, score_valid}, 32'd0);
        send(2'd2, 7'h24);
        exp_q.push_back(16'h1234);
        send(2'd3, 7'h79);
        chk("ord_valid", {31'd0, score_valid}, 32'd1);
        chk("ord_out",   {16'h0000, score_out}, 32'h1234);
        chk("ord_ready", {31'd0, seg_ready}, 32'd0);
        release_frame();
        chk("ord_out_kept", {16'h0000, score_out}, 32'h1234);

        // Out of order with overwrite.
        send(2'd3, 7'h0E);
        send(2'd0, 7'h40);
        send(2'd0, 7'h21);
        send(2'd2, 7'h46);
        exp_q.push_back(16'hFCBD);
        send(2'd1, 7'h03);
        chk("ooo_valid", {31'd0, score_valid}, 32'd1);
        chk("ooo_out",   {16'h0000, score_out}, 32'hFCBD);

        // Backpressure: beats offered during HOLD must be ignored.
        seg_valid = 1'b1;
        seg_in    = 7'h00;
        digit_idx = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out",   {16'h0000, score_out}, 32'hFCBD);
            chk("bp_ready", {31'd0, seg_ready}, 32'd0);
        end
        score_ready = 1'b1;
        @(posedge clk); #1;
        seg_valid   = 1'b0;
        score_ready = 1'b0;
        chk("bp_release", {31'd0, score_valid}, 32'd0);
        send(2'd0, 7'h12);
        send(2'd1, 7'h02);
        send(2'd2, 7'h78);
        chk("bp_mask_empty", {31'd0, score_valid}, 32'd0);
        exp_q.push_back(16'h8765);
        send(2'd3, 7'h00);
        chk("bp_next_valid", {31'd0, score_valid}, 32'd1);
        release_frame();

        // Illegal pattern on idx1.
        send(2'd0, 7'h40);
        send(2'd1, 7'h7F);
`ifdef SEGDEC_ERR_EN
        chk("ill_err_hi", {31'd0, err}, 32'd1);
`else
        chk("ill_err_lo", {31'd0, err}, 32'd0);
`endif
        send(2'd2, 7'h40);
        chk("ill_err_pulse", {31'd0, err}, 32'd0);
`ifdef SEGDEC_ERR_EN
        send(2'd3, 7'h40);
        chk("ill_no_valid", {31'd0, score_valid}, 32'd0);
        exp_q.push_back(16'h0010);
        send(2'd1, 7'h79);
        chk("ill_fix_valid", {31'd0, score_valid}, 32'd1);
        chk("ill_fix_out",   {16'h0000, score_out}, 32'h0010);
`else
        exp_q.push_back(16'h0000);
        send(2'd3, 7'h40);
        chk("ill_valid", {31'd0, score_valid}, 32'd1);
        chk("ill_out",   {16'h0000, score_out}, 32'h0000);
        chk("ill_err",   {31'd0, err}, 32'd0);
`endif
        release_frame();

        // Abort with enable low mid-frame.
        send(2'd0, 7'h19);
        send(2'd1, 7'h30);
        send(2'd2, 7'h24);
        enable = 1'b0;
        @(posedge clk); #1;
        enable = 1'b1;
        chk("en_out",   {16'h0000, score_out}, 32'h0000);
        chk("en_valid", {31'd0, score_valid}, 32'd0);
        chk("en_ready", {31'd0, seg_ready}, 32'd1);
        chk("en_err",   {31'd0, err}, 32'd0);
        send(2'd0, 7'h08);
        send(2'd1, 7'h03);
        send(2'd2, 7'h46);
        chk("en_mask_clr", {31'd0, score_valid}, 32'd0);
        exp_q.push_back(16'hDCBA);
        send(2'd3, 7'h21);
        chk("en_frame_valid", {31'd0, score_valid}, 32'd1);

        // Reset asserted during HOLD.
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        chk("hold_rst_valid", {31'd0, score_valid}, 32'd0);
        chk("hold_rst_out",   {16'h0000, score_out}, 32'h0000);
        chk("hold_rst_ready", {31'd0, seg_ready}, 32'd1);
        send(2'd0, 7'h18);
        send(2'd1, 7'h18);
        send(2'd2, 7'h06);
        exp_q.push_back(16'hFE99);
        send(2'd3, 7'h0E);
        chk("post_rst_out", {16'h0000, score_out}, 32'hFE99);
        release_frame();

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/score_segment_decoder.md
# score_segment_decoder

Receives a time-multiplexed stream of active-low seven-segment digit patterns, decodes each back to a 4-bit hex nibble, and reassembles the 16-bit score once all four digit positions have been captured. It is the receive-side counterpart of the score display path and is used for display loopback self-check and for reading scores from a multiplexed external display bus. The assembled score is offered on a valid/ready output handshake.

## Interface
- Parameters: none. The width is fixed at 4 digits, giving a 16-bit score.
- clk  in  1  system clock; all state updates on the rising edge
- resetn  in  1  synchronous, active-low reset
- enable  in  1  when low, has the same effect as reset on the next edge
- seg_valid  in  1  seg_in/digit_idx carry a digit beat
- seg_ready  out  1  block can accept a beat (beat accepted when seg_valid & seg_ready)
- seg_in  in  7  segment pattern; bit i = segment i; 0 = lit, 1 = off
- digit_idx  in  2  digit position: 0 = score[3:0] … 3 = score[15:12]
- score_out  out  16  assembled score, stable while score_valid = 1
- score_valid  out  1  score_out holds a complete frame
- score_ready  in  1  consumer accepts the frame
- err  out  1  one-cycle pulse for an illegal pattern (only when SEGDEC_ERR_EN is defined)

## Operation
- Legal patterns for seg_in[6:0] → nibble:
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3
  - 0x19→4, 0x12→5, 0x02→6, 0x78→7
  - 0x00→8, 0x18→9, 0x08→A, 0x03→B
  - 0x46→C, 0x21→D, 0x06→E, 0x0E→F
  - All other 112 codes are illegal.
- State is held in a 4×4 digit register file, a 4-bit capture mask, and a 2-state FSM.
- FSM state COLLECT:
  - seg_ready = 1.
  - On an accepted beat with a legal pattern: write the nibble to digit[digit_idx] and set mask[digit_idx].
  - A repeated digit_idx overwrites the stored nibble; the most recent beat wins.
- COLLECT → HOLD: on the edge where an accepted legal beat makes the mask 4'b1111. On that same edge:
  - score_out ← {digit3, digit2, digit1, digit0}, including the nibble just written;
  - score_valid ← 1.
- FSM state HOLD:
  - seg_ready = 0, so beats are ignored and not accepted.
  - score_out and score_valid are held until score_ready = 1.
- HOLD → COLLECT: on an edge with score_ready = 1. On that edge: score_valid ← 0 and mask ← 0. score_out keeps its last value.
- Illegal pattern in COLLECT:
  - The digit register is not written and mask[digit_idx] is cleared.
  - A partial frame therefore needs a fresh legal beat for that position.
- Reset, or enable = 0: on the edge, FSM → COLLECT, mask = 0, digits = 0, score_out = 0, score_valid = 0, err = 0. This also applies mid-frame and while in HOLD, and it discards any pending frame.

## Timing
- Reset values: seg_ready = 1 (combinational from COLLECT), score_out = 16'h0000, score_valid = 0, err = 0.
- Latency: the fourth distinct legal beat is sampled at edge t, and score_valid = 1 from edge t. This is one edge, with no extra pipeline stage.
- Throughput: minimum of 4 accepted beats plus 1 HOLD cycle per frame. This minimum applies when score_ready is held high, since HOLD always lasts at least one cycle.
- seg_ready depends only on the FSM state. It never combinationally depends on seg_valid or score_ready.
- err is registered: it is high for exactly the one cycle after the edge that sampled the illegal accepted beat.
- A beat presented while in HOLD is not accepted; the producer must hold it until seg_ready = 1.
- Simultaneous events:
  - resetn = 0 or enable = 0 dominates everything.
  - A completing beat and an illegal beat cannot coincide, since only one beat is taken per cycle.

## Configuration
- SEGDEC_ERR_EN defined:
  - Illegal patterns are detected.
  - err pulses as specified.
  - The illegal beat clears the mask bit and leaves the digit untouched.
- SEGDEC_ERR_EN undefined:
  - No legality check is made; illegal patterns decode to nibble 0.
  - The beat is treated as legal: it is written and sets its mask bit.
  - err is tied to 0.

## Test plan
- **Ordered frame.** After reset, send beats idx0 = 0x19, idx1 = 0x30, idx2 = 0x24, idx3 = 0x79 with score_ready = 0.
  - Required: score_valid rises on the edge of the 4th beat, score_out = 16'h1234, seg_ready = 0.
  - Then raise score_ready: on the next edge score_valid = 0 and seg_ready = 1.
- **Out of order with overwrite.** Send idx3 = 0x0E, idx0 = 0x40, idx0 = 0x21, idx2 = 0x46, idx1 = 0x03.
  - Required: score_out = 16'hFCBD.
- **Backpressure.** Drive seg_valid continuously during HOLD with 0x00 on idx0.
  - Required: no beat is accepted and score_out is unchanged for 5 cycles.
  - Release score_ready: the next frame starts cleanly, with the mask empty.
- **Illegal pattern (SEGDEC_ERR_EN defined).** Send idx0 = 0x40, idx1 = 0x7F, idx2 = 0x40, idx3 = 0x40.
  - Required: err is high for 1 cycle and there is no score_valid.
  - Then send idx1 = 0x79: score_out = 16'h0010.
- **Illegal pattern (SEGDEC_ERR_EN undefined).** Repeat the previous sequence.
  - Required: score_valid on the 4th beat with score_out = 16'h0000, and err stays 0.
- **Abort.** Accept 3 beats, then drive enable = 0 for 1 cycle.
  - Required: outputs at reset values and the mask cleared; a following complete frame decodes correctly.
  - Repeat with resetn = 0 asserted during HOLD: score_valid drops on that edge.
